// File: rtl/enemy_spawner.sv
// enemy_spawner: schedules enemy spawns into free Enemy slots with wave-based difficulty.
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   enable     in   game running; low freezes all state and masks pulses
//   slotDead   in   [NUM_SLOTS] dead flag per Enemy slot
//   canSpawn   out  [NUM_SLOTS] one-hot single-cycle spawn pulse
//   spawnType  out  [2] enemy type for the pulse (01/10/11)
//   wave       out  [4] current wave, saturating at 15
//   spawnCount out  [3] spawns completed in the current wave
//   bossSpawn  out  boss pulse alongside canSpawn, only with BOSS_WAVE_EN defined
module enemy_spawner #(
    parameter int         NUM_SLOTS      = 4,
    parameter int         SPAWN_INTERVAL = 200,
    parameter int         INTERVAL_STEP  = 16,
    parameter int         MIN_INTERVAL   = 40,
    parameter int         WAVE_LEN       = 8,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_SLOTS-1:0] slotDead,
    output logic [NUM_SLOTS-1:0] canSpawn,
    output logic [1:0]           spawnType,
    output logic [3:0]           wave,
    output logic [2:0]           spawnCount,
    output logic                 bossSpawn
);
    localparam int SW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
    localparam logic [11:0] SI = 12'(SPAWN_INTERVAL);
    localparam logic [11:0] ST = 12'(INTERVAL_STEP);
    localparam logic [11:0] MI = 12'(MIN_INTERVAL);
    localparam logic [2:0]  LAST = 3'(WAVE_LEN - 1);

    typedef enum logic [1:0] {S_WAIT, S_PICK, S_ISSUE} state_t;

    state_t                     state_q, state_d;
    logic [11:0]                cnt_q, cnt_d;
    logic [7:0]                 lfsr_q, lfsr_d;
    logic [NUM_SLOTS-1:0]       pending_q, pending_d;
    logic [NUM_SLOTS-1:0][2:0]  timer_q, timer_d;
    logic [SW-1:0]              slot_q, slot_d;
    logic [1:0]                 type_q, type_d;
    logic [3:0]                 wave_q, wave_d;
    logic [2:0]                 count_q, count_d;

    logic [11:0]          dec, interval;
    logic [NUM_SLOTS-1:0] free;
    logic                 found, last, boss_hit, fire;
    logic [SW-1:0]        pick;
    logic [1:0]           lfsr_type, pick_type;

    // Underflow of the subtraction (dec > SI) clamps to the floor as well.
    assign dec      = 12'(wave_q) * ST;
    assign interval = (dec > SI || SI - dec < MI) ? MI : SI - dec;

    // A slot that just turned dead this cycle already counts as free.
    assign free = slotDead & ~pending_q;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free[i]) begin
                found = 1'b1;
                pick  = SW'(i);
            end
        end
    end

    // Wave >= 2 maps lfsr 00/01 to the weakest type and passes 10/11 through.
    assign lfsr_type = wave_q == 4'd0 ? 2'b01 :
                       wave_q == 4'd1 ? (lfsr_q[0] ? 2'b10 : 2'b01) :
                       lfsr_q[1] ? lfsr_q[1:0] : 2'b01;
    assign last = count_q == LAST;

`ifdef BOSS_WAVE_EN
    // wave_q/count_q only advance when leaving S_ISSUE, so they still
    // describe the spawn being issued during the pulse.
    assign boss_hit = wave_q[1:0] == 2'b11 && last;
`else
    assign boss_hit = 1'b0;
`endif

    assign pick_type = boss_hit ? 2'b11 : lfsr_type;
    assign fire      = enable && state_q == S_ISSUE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lfsr_d    = lfsr_q;
        pending_d = pending_q;
        timer_d   = timer_q;
        slot_d    = slot_q;
        type_d    = type_q;
        wave_d    = wave_q;
        count_d   = count_q;
        if (enable) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            // Pending drops once the Enemy goes live or after a 4-cycle hold
            // when it never accepted the spawn.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (pending_q[i]) begin
                    if (!slotDead[i] || timer_q[i] == 3'd3) pending_d[i] = 1'b0;
                    else timer_d[i] = timer_q[i] + 3'd1;
                end
            end
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == interval - 12'd1) begin
                        cnt_d   = '0;
                        state_d = S_PICK;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                S_PICK: begin
                    if (found) begin
                        slot_d  = pick;
                        type_d  = pick_type;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    pending_d[slot_q] = 1'b1;
                    timer_d[slot_q]   = 3'd0;
                    count_d = last ? 3'd0 : count_q + 3'd1;
                    wave_d  = last && wave_q != 4'd15 ? wave_q + 4'd1 : wave_q;
                    state_d = S_WAIT;
                end
                default: state_d = S_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_WAIT;
            cnt_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            pending_q <= '0;
            timer_q   <= '0;
            slot_q    <= '0;
            type_q    <= 2'b01;
            wave_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            slot_q    <= slot_d;
            type_q    <= type_d;
            wave_q    <= wave_d;
            count_q   <= count_d;
        end
    end

    assign canSpawn   = fire ? (NUM_SLOTS'(1) << slot_q) : '0;
    assign spawnType  = type_q;
    assign wave       = wave_q;
    assign spawnCount = count_q;
    assign bossSpawn  = fire && boss_hit;
endmodule

// File: tb/tb_enemy_spawner.sv
// tb_enemy_spawner: directed scoreboard bench for enemy_spawner.
`timescale 1ns/1ps
module tb_enemy_spawner;
    localparam int NS = 4, SI = 200, ST = 16, MI = 40, WL = 8;
    localparam logic [7:0] SEED = 8'hA5;
`ifdef BOSS_WAVE_EN
    localparam bit BOSS = 1'b1;
`else
    localparam bit BOSS = 1'b0;
`endif

    typedef struct {
        int         lat;
        logic [3:0] slot;
        logic [1:0] typ;
        logic       boss;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] slotDead = 4'b0000;
    logic [3:0] canSpawn;
    logic [1:0] spawnType;
    logic [3:0] wave;
    logic [2:0] spawnCount;
    logic       bossSpawn;

    int         errors = 0;
    int         checks = 0;
    exp_t       sb[$];
    logic [7:0] lfsr_m = SEED;
    int         w_m = 0;
    int         c_m = 0;

    enemy_spawner #(
        .NUM_SLOTS(NS), .SPAWN_INTERVAL(SI), .INTERVAL_STEP(ST),
        .MIN_INTERVAL(MI), .WAVE_LEN(WL), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .slotDead(slotDead),
        .canSpawn(canSpawn), .spawnType(spawnType), .wave(wave),
        .spawnCount(spawnCount), .bossSpawn(bossSpawn)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lstep(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic int ival(input int w);
        int v;
        v = SI - w * ST;
        return v < MI ? MI : v;
    endfunction

    function automatic logic [1:0] etype(input int w, input logic [7:0] l);
        if (w == 0) return 2'b01;
        if (w == 1) return l[0] ? 2'b10 : 2'b01;
        case (l[1:0])
            2'b10:   return 2'b10;
            2'b11:   return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset && enable) lfsr_m = lstep(lfsr_m);
        #1;
    endtask

    // Pushes the predicted spawn, waits (bounded) for the pulse, optionally
    // pauses enable while the pulse is pending, then checks it.
    task automatic spawn(input int lat, input logic [3:0] slot, input int pause);
        exp_t       e;
        int         n;
        int         bad;
        logic [7:0] l;
        l = lfsr_m;
        for (int i = 0; i < lat - 1; i++) l = lstep(l);
        e.boss = BOSS && (w_m % 4 == 3) && (c_m == WL - 1);
        e.typ  = e.boss ? 2'b11 : etype(w_m, l);
        e.lat  = lat;
        e.slot = slot;
        sb.push_back(e);
        n = 0;
        while (canSpawn === 4'b0000 && n < lat + 4) begin
            tick();
            n++;
        end
        if (pause > 0) begin
            enable = 1'b0;
            #1;
            chk("pause_gate", 32'(canSpawn), 32'd0);
            bad = 0;
            repeat (pause) begin
                tick();
                if (canSpawn !== 4'b0000 || bossSpawn !== 1'b0) bad++;
            end
            chk("pause_quiet", 32'(bad), 32'd0);
            enable = 1'b1;
            #1;
        end
        e = sb.pop_front();
        chk("latency", 32'(n), 32'(e.lat));
        chk("slot", 32'(canSpawn), 32'(e.slot));
        chk("type", 32'(spawnType), 32'(e.typ));
        chk("boss", 32'(bossSpawn), 32'(e.boss));
        c_m++;
        if (c_m == WL) begin
            c_m = 0;
            if (w_m < 15) w_m++;
        end
        tick();
        chk("one_pulse", 32'(canSpawn), 32'd0);
        chk("count", 32'(spawnCount), 32'(c_m));
        chk("wave", 32'(wave), 32'(w_m));
    endtask

    initial begin
        int bad;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_can", 32'(canSpawn), 32'd0);
        chk("rst_type", 32'(spawnType), 32'd1);
        chk("rst_wave", 32'(wave), 32'd0);
        chk("rst_count", 32'(spawnCount), 32'd0);
        chk("rst_boss", 32'(bossSpawn), 32'd0);
        enable = 1'b1;
        slotDead = 4'b1111;
        reset = 1'b1;
        spawn(ival(0) + 1, 4'b0001, 0);
        slotDead = 4'b1110;
        spawn(ival(0) + 1, 4'b0010, 0);
        slotDead = 4'b1101;
        spawn(ival(0) + 1, 4'b0001, 0);
        spawn(ival(0) + 1, 4'b0001, 0);
        slotDead = 4'b0000;
        bad = 0;
        repeat (ival(w_m) + 51) begin
            tick();
            if (canSpawn !== 4'b0000) bad++;
        end
        chk("stall_quiet", 32'(bad), 32'd0);
        slotDead = 4'b0100;
        spawn(1, 4'b0100, 0);
        slotDead = 4'b1111;
        while (w_m < 15)
            spawn(ival(w_m) + 1, 4'b0001, (w_m == 2 && c_m == 0) ? 30 : 0);
        repeat (WL) spawn(ival(w_m) + 1, 4'b0001, 0);
        repeat (ival(w_m) + 1) tick();
        chk("pre_reset_pulse", 32'(canSpawn), 32'd1);
        reset = 1'b0;
        #1;
        chk("async_drop", 32'(canSpawn), 32'd0);
        chk("mid_rst_wave", 32'(wave), 32'd0);
        chk("mid_rst_count", 32'(spawnCount), 32'd0);
        chk("mid_rst_type", 32'(spawnType), 32'd1);
        w_m = 0;
        c_m = 0;
        lfsr_m = SEED;
        tick();
        reset = 1'b1;
        spawn(ival(0) + 1, 4'b0001, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
